// File: rtl/vx_csr_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_unit_pkg
// Description : Shared types, widths and CSR addresses for the CSR issue unit.
// Revision    : 1.0
// ============================================================================
package vx_csr_unit_pkg;

    localparam int VX_NUM_THREADS = 4;
    localparam int VX_NUM_WARPS   = 4;
    localparam int NW_BITS        = 2;
    localparam int NR_BITS        = 5;
    localparam int CSR_ADDR_BITS  = 12;
    localparam int CSR_WIDTH      = 32;

    localparam logic [CSR_ADDR_BITS-1:0] CSR_FFLAGS   = 12'h001;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FRM      = 12'h002;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_FCSR     = 12'h003;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MSTATUS  = 12'h300;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_MSCRATCH = 12'h340;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_WTID     = 12'hCC0;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_LTID     = 12'hCC1;
    localparam logic [CSR_ADDR_BITS-1:0] CSR_GTID     = 12'hCC2;

    typedef enum logic [1:0] {
        CSR_RW = 2'd1,
        CSR_RS = 2'd2,
        CSR_RC = 2'd3
    } csr_op_t;

    typedef struct packed {
        logic [NW_BITS-1:0]               wid;
        logic [VX_NUM_THREADS-1:0]        tmask;
        logic [31:0]                      pc;
        logic [NR_BITS-1:0]               rd;
        logic                             wb;
        logic [VX_NUM_THREADS-1:0][31:0]  data;
    } csr_rsp_t;

    // Floating-point status CSRs are updated asynchronously by the FPU.
    function automatic logic is_fpu_csr(input logic [CSR_ADDR_BITS-1:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_csr_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_unit_if
// Description : Dispatch request, CSR data-block port and commit response bus.
// Revision    : 1.0
// ============================================================================
interface vx_csr_unit_if;
    import vx_csr_unit_pkg::*;

    logic                             req_valid;
    logic                             req_ready;
    logic [NW_BITS-1:0]               req_wid;
    logic [VX_NUM_THREADS-1:0]        req_tmask;
    logic [31:0]                      req_PC;
    logic [NR_BITS-1:0]               req_rd;
    logic                             req_wb;
    csr_op_t                          req_op;
    logic                             req_use_imm;
    logic [4:0]                       req_imm;
    logic [CSR_ADDR_BITS-1:0]         req_addr;
    logic [31:0]                      req_rs1_data;
    logic [VX_NUM_WARPS-1:0]          fpu_pending;

    logic                             read_enable;
    logic [CSR_ADDR_BITS-1:0]         read_addr;
    logic [NW_BITS-1:0]               read_wid;
    logic [31:0]                      read_data;
    logic                             write_enable;
    logic [CSR_ADDR_BITS-1:0]         write_addr;
    logic [NW_BITS-1:0]               write_wid;
    logic [CSR_WIDTH-1:0]             write_data;

    logic                             busy;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [NW_BITS-1:0]               rsp_wid;
    logic [VX_NUM_THREADS-1:0]        rsp_tmask;
    logic [31:0]                      rsp_PC;
    logic [NR_BITS-1:0]               rsp_rd;
    logic                             rsp_wb;
    logic [VX_NUM_THREADS-1:0][31:0]  rsp_data;

    modport master (
        output req_valid, req_wid, req_tmask, req_PC, req_rd, req_wb, req_op,
               req_use_imm, req_imm, req_addr, req_rs1_data, fpu_pending,
               read_data, rsp_ready,
        input  req_ready, read_enable, read_addr, read_wid, write_enable,
               write_addr, write_wid, write_data, busy, rsp_valid, rsp_wid,
               rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data
    );

    modport slave (
        input  req_valid, req_wid, req_tmask, req_PC, req_rd, req_wb, req_op,
               req_use_imm, req_imm, req_addr, req_rs1_data, fpu_pending,
               read_data, rsp_ready,
        output req_ready, read_enable, read_addr, read_wid, write_enable,
               write_addr, write_wid, write_data, busy, rsp_valid, rsp_wid,
               rsp_tmask, rsp_PC, rsp_rd, rsp_wb, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/vx_csr_unit_skid.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_unit_skid
// Description : Two-entry in-order valid/ready buffer (head register + skid).
// Revision    : 1.0
// ============================================================================
module vx_csr_unit_skid #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DATAW-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DATAW-1:0] out_data_o
);

    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [DATAW-1:0] head_data_q,  head_data_d;
    logic [DATAW-1:0] skid_data_q,  skid_data_d;
    logic             w_push;
    logic             w_pop;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = head_valid_q;
    assign out_data_o  = head_data_q;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = head_valid_q & out_ready_i;

    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_data_d  = head_data_q;
        skid_data_d  = skid_data_q;
        if (!head_valid_q || w_pop) begin
            // A held skid entry is older than anything arriving now.
            if (skid_valid_q) begin
                head_valid_d = 1'b1;
                head_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = w_push;
                if (w_push) begin
                    head_data_d = in_data_i;
                end
            end
        end else if (w_push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
        end
        head_data_q <= head_data_d;
        skid_data_q <= skid_data_d;
    end

endmodule
`default_nettype wire

// File: rtl/vx_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : vx_csr_unit
// Description : CSR read-modify-write issue with buffered per-lane writeback.
// Revision    : 1.0
// ============================================================================
module vx_csr_unit
    import vx_csr_unit_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_THREADS = VX_NUM_THREADS,
    parameter int NUM_WARPS   = VX_NUM_WARPS
) (
    input  logic         clk,
    input  logic         reset,
    vx_csr_unit_if.slave csr_if
);

    logic        w_fpu_stall;
    logic        w_buf_in_ready;
    logic        w_head_valid;
    logic        w_fire;
    logic        w_src_nz;
    logic        w_wr_en;
    logic [31:0] w_src;
    logic [31:0] w_new_val;
    logic [31:0] w_gtid_base;
    csr_rsp_t    w_rsp_in;
    csr_rsp_t    w_rsp_out;

    assign w_fpu_stall = csr_if.req_valid
                       & csr_if.fpu_pending[csr_if.req_wid]
                       & is_fpu_csr(csr_if.req_addr);

    assign csr_if.req_ready = ~reset & w_buf_in_ready & ~w_fpu_stall;
    assign w_fire           = csr_if.req_valid & csr_if.req_ready;

    // The rs1 index and the immediate share one field; zero means "no write" for RS/RC.
    assign w_src    = csr_if.req_use_imm ? 32'(csr_if.req_imm) : csr_if.req_rs1_data;
    assign w_src_nz = (csr_if.req_imm != 5'd0);

    always_comb begin
        w_new_val = w_src;
        w_wr_en   = 1'b0;
        case (csr_if.req_op)
            CSR_RW: begin
                w_new_val = w_src;
                w_wr_en   = 1'b1;
            end
            CSR_RS: begin
                w_new_val = csr_if.read_data | w_src;
                w_wr_en   = w_src_nz;
            end
            CSR_RC: begin
                w_new_val = csr_if.read_data & ~w_src;
                w_wr_en   = w_src_nz;
            end
            default: begin
                w_new_val = w_src;
                w_wr_en   = 1'b0;
            end
        endcase
    end

    assign csr_if.read_enable  = w_fire;
    assign csr_if.read_addr    = csr_if.req_addr;
    assign csr_if.read_wid     = csr_if.req_wid;
    assign csr_if.write_enable = w_fire & w_wr_en;
    assign csr_if.write_addr   = csr_if.req_addr;
    assign csr_if.write_wid    = csr_if.req_wid;
    assign csr_if.write_data   = w_new_val;

    assign w_gtid_base = (32'(CORE_ID) * 32'(NUM_WARPS) + 32'(csr_if.req_wid)) * 32'(NUM_THREADS);

    always_comb begin
        w_rsp_in       = '0;
        w_rsp_in.wid   = csr_if.req_wid;
        w_rsp_in.tmask = csr_if.req_tmask;
        w_rsp_in.pc    = csr_if.req_PC;
        w_rsp_in.rd    = csr_if.req_rd;
        w_rsp_in.wb    = csr_if.req_wb;
        for (int i = 0; i < NUM_THREADS; i++) begin
            case (csr_if.req_addr)
                CSR_WTID, CSR_LTID: w_rsp_in.data[i] = 32'(i);
                CSR_GTID:           w_rsp_in.data[i] = w_gtid_base + 32'(i);
                default:            w_rsp_in.data[i] = csr_if.read_data;
            endcase
        end
    end

    vx_csr_unit_skid #(
        .DATAW ($bits(csr_rsp_t))
    ) u_rsp_buf (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (w_fire),
        .in_ready_o  (w_buf_in_ready),
        .in_data_i   (w_rsp_in),
        .out_valid_o (w_head_valid),
        .out_ready_i (csr_if.rsp_ready),
        .out_data_o  (w_rsp_out)
    );

    assign csr_if.rsp_valid = w_head_valid;
    assign csr_if.rsp_wid   = w_rsp_out.wid;
    assign csr_if.rsp_tmask = w_rsp_out.tmask;
    assign csr_if.rsp_PC    = w_rsp_out.pc;
    assign csr_if.rsp_rd    = w_rsp_out.rd;
    assign csr_if.rsp_wb    = w_rsp_out.wb;
    assign csr_if.rsp_data  = w_rsp_out.data;

    // The skid slot is occupied exactly when the buffer refuses new entries.
    assign csr_if.busy = w_fire | w_head_valid | ~w_buf_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_vx_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_csr_unit
// Description : Directed self-checking bench with a queue-based reference model.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_vx_csr_unit;
    import vx_csr_unit_pkg::*;

    localparam int CORE_ID = 1;
    localparam int NT      = VX_NUM_THREADS;
    localparam int NWARP   = VX_NUM_WARPS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vx_csr_unit_if bus();

    vx_csr_unit #(
        .CORE_ID     (CORE_ID),
        .NUM_THREADS (NT),
        .NUM_WARPS   (NWARP)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .csr_if (bus)
    );

    // CSR data block: combinational read, write lands at the clock edge.
    bit [31:0] mem [NWARP][4096];
    assign bus.read_data = mem[bus.read_wid][bus.read_addr];
    always @(posedge clk) begin
        if (bus.write_enable) mem[bus.write_wid][bus.write_addr] <= bus.write_data;
    end

    typedef struct {
        logic [1:0]          wid;
        logic [NT-1:0]       tmask;
        logic [31:0]         pc;
        logic [4:0]          rd;
        logic                wb;
        logic [NT-1:0][31:0] data;
    } exp_t;

    exp_t        mq[$];
    bit   [31:0] gold [NWARP][4096];
    logic [31:0] rsp_log0[$];
    logic [31:0] rsp_log3[$];
    logic [31:0] wr_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pc_seq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: output buffer is a FIFO of depth 2, CSR state is an array.
    logic        rst_prev = 1'b0;
    logic        m_stall, m_ready, m_fire, m_we, m_busy;
    logic [31:0] m_src, m_old, m_nv;
    exp_t        m_e;

    always @(negedge clk) begin
        if (reset) begin
            chk1("rst_read_enable", bus.read_enable, 1'b0);
            chk1("rst_write_enable", bus.write_enable, 1'b0);
            chk1("rst_req_ready", bus.req_ready, 1'b0);
            if (rst_prev) begin
                chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
                chk1("rst_busy", bus.busy, 1'b0);
            end
            mq.delete();
        end else begin
            m_stall = bus.req_valid && bus.fpu_pending[bus.req_wid] &&
                      (bus.req_addr == CSR_FFLAGS || bus.req_addr == CSR_FRM ||
                       bus.req_addr == CSR_FCSR);
            m_ready = (mq.size() < 2) && !m_stall;
            m_fire  = bus.req_valid && m_ready;
            m_busy  = m_fire || (mq.size() != 0);
            chk1("req_ready", bus.req_ready, m_ready);
            chk1("rsp_valid", bus.rsp_valid, mq.size() != 0);
            chk1("busy", bus.busy, m_busy);
            chk1("read_enable", bus.read_enable, m_fire);

            if (mq.size() != 0 && bus.rsp_valid) begin
                chk("rsp_wid", 32'(bus.rsp_wid), 32'(mq[0].wid));
                chk("rsp_tmask", 32'(bus.rsp_tmask), 32'(mq[0].tmask));
                chk("rsp_PC", bus.rsp_PC, mq[0].pc);
                chk("rsp_rd", 32'(bus.rsp_rd), 32'(mq[0].rd));
                chk1("rsp_wb", bus.rsp_wb, mq[0].wb);
                for (int i = 0; i < NT; i++) begin
                    if (mq[0].tmask[i]) chk("rsp_data", bus.rsp_data[i], mq[0].data[i]);
                end
            end
            if (mq.size() != 0 && bus.rsp_ready) begin
                rsp_log0.push_back(bus.rsp_data[0]);
                rsp_log3.push_back(bus.rsp_data[NT-1]);
                void'(mq.pop_front());
            end

            m_src = bus.req_use_imm ? {27'd0, bus.req_imm} : bus.req_rs1_data;
            m_old = gold[bus.req_wid][bus.req_addr];
            m_we  = 1'b0;
            m_nv  = m_src;
            if (bus.req_op == CSR_RW) begin
                m_we = m_fire;
                m_nv = m_src;
            end else if (bus.req_op == CSR_RS) begin
                m_we = m_fire && (bus.req_imm != 5'd0);
                m_nv = m_old | m_src;
            end else if (bus.req_op == CSR_RC) begin
                m_we = m_fire && (bus.req_imm != 5'd0);
                m_nv = m_old & ~m_src;
            end
            chk1("write_enable", bus.write_enable, m_we);

            if (m_fire) begin
                chk("read_addr", 32'(bus.read_addr), 32'(bus.req_addr));
                chk("read_wid", 32'(bus.read_wid), 32'(bus.req_wid));
            end
            if (m_we) begin
                chk("write_addr", 32'(bus.write_addr), 32'(bus.req_addr));
                chk("write_wid", 32'(bus.write_wid), 32'(bus.req_wid));
                chk("write_data", bus.write_data, m_nv);
                wr_log.push_back(bus.write_data);
                gold[bus.req_wid][bus.req_addr] = m_nv;
            end
            if (m_fire) begin
                m_e.wid   = bus.req_wid;
                m_e.tmask = bus.req_tmask;
                m_e.pc    = bus.req_PC;
                m_e.rd    = bus.req_rd;
                m_e.wb    = bus.req_wb;
                for (int i = 0; i < NT; i++) begin
                    if (bus.req_addr == CSR_WTID || bus.req_addr == CSR_LTID)
                        m_e.data[i] = 32'(i);
                    else if (bus.req_addr == CSR_GTID)
                        m_e.data[i] = 32'((CORE_ID * NWARP + int'(bus.req_wid)) * NT + i);
                    else
                        m_e.data[i] = m_old;
                end
                mq.push_back(m_e);
            end
        end
        rst_prev = reset;
    end

    task automatic drive_req(input logic [1:0] wid, input logic [NT-1:0] tm, input csr_op_t op,
                             input logic ui, input logic [4:0] imm, input logic [11:0] addr,
                             input logic [31:0] rs1);
        pc_seq++;
        bus.req_valid    = 1'b1;
        bus.req_wid      = wid;
        bus.req_tmask    = tm;
        bus.req_op       = op;
        bus.req_use_imm  = ui;
        bus.req_imm      = imm;
        bus.req_addr     = addr;
        bus.req_rs1_data = rs1;
        bus.req_PC       = 32'h8000_0000 + 32'(pc_seq * 4);
        bus.req_rd       = 5'(pc_seq);
        bus.req_wb       = pc_seq[0];
    endtask

    // Holds the request until accepted; returns the number of refused cycles.
    task automatic issue(input logic [1:0] wid, input logic [NT-1:0] tm, input csr_op_t op,
                         input logic ui, input logic [4:0] imm, input logic [11:0] addr,
                         input logic [31:0] rs1, output int waited);
        drive_req(wid, tm, op, ui, imm, addr, rs1);
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 40) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: actual=no-accept required=accept within 40 cycles");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    logic [31:0] exp_rsp0 [17];
    initial begin : stim
        int w;
        exp_rsp0 = '{32'h0, 32'h1234, 32'h12F4, 32'h12F0, 32'h12F0, 32'h12F0, 32'h0,
                     32'd0, 32'd0, 32'd24,
                     32'h0, 32'hAAAA_0001, 32'hBBBB_0002,
                     32'h0, 32'h0, 32'hDDDD_0004, 32'hCCCC_0003};
        bus.req_valid    = 1'b0;
        bus.req_wid      = '0;
        bus.req_tmask    = '0;
        bus.req_PC       = '0;
        bus.req_rd       = '0;
        bus.req_wb       = 1'b0;
        bus.req_op       = CSR_RW;
        bus.req_use_imm  = 1'b0;
        bus.req_imm      = '0;
        bus.req_addr     = '0;
        bus.req_rs1_data = '0;
        bus.fpu_pending  = '0;
        bus.rsp_ready    = 1'b1;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Read-modify-write arithmetic on mstatus
        issue(2'd0, 4'hF, CSR_RW, 1'b0, 5'd5,  CSR_MSTATUS, 32'h0000_1234, w);
        issue(2'd0, 4'hF, CSR_RS, 1'b0, 5'd6,  CSR_MSTATUS, 32'h0000_00F0, w);
        issue(2'd0, 4'hF, CSR_RC, 1'b0, 5'd7,  CSR_MSTATUS, 32'h0000_0004, w);
        issue(2'd0, 4'hF, CSR_RS, 1'b1, 5'd0,  CSR_MSTATUS, 32'hDEAD_BEEF, w);
        issue(2'd0, 4'h3, CSR_RC, 1'b0, 5'd0,  CSR_MSTATUS, 32'h0000_FFFF, w);
        issue(2'd0, 4'hF, CSR_RW, 1'b1, 5'd0,  CSR_MSTATUS, 32'h5555_5555, w);
        issue(2'd0, 4'hF, CSR_RS, 1'b1, 5'h1F, CSR_MSTATUS, 32'h0000_0000, w);

        // Thread-id CSRs for warp 2 on core 1
        issue(2'd2, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_WTID, 32'h0, w);
        issue(2'd2, 4'h9, CSR_RS, 1'b1, 5'd0, CSR_LTID, 32'h0, w);
        issue(2'd2, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_GTID, 32'h0, w);
        idle(3);

        // Commit back-pressure: two entries fit, the third waits for release
        bus.rsp_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join_none
        issue(2'd1, 4'hF, CSR_RW, 1'b0, 5'd3, CSR_MSCRATCH, 32'hAAAA_0001, w);
        chk("bp_first_wait", 32'(w), 32'd0);
        issue(2'd1, 4'hF, CSR_RW, 1'b0, 5'd3, CSR_MSCRATCH, 32'hBBBB_0002, w);
        chk("bp_second_wait", 32'(w), 32'd0);
        issue(2'd1, 4'hF, CSR_RW, 1'b0, 5'd3, CSR_MSCRATCH, 32'hCCCC_0003, w);
        chk("bp_third_wait", 32'(w), 32'd4);
        idle(4);

        // FPU flag hazard on warp 1 only
        bus.fpu_pending = 4'b0010;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 bus.fpu_pending = '0;
            end
        join_none
        issue(2'd1, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_FCSR, 32'h0, w);
        chk("fpu_stall_wait", 32'(w), 32'd4);
        bus.fpu_pending = 4'b0010;
        issue(2'd0, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_FCSR, 32'h0, w);
        chk("fpu_other_warp_wait", 32'(w), 32'd0);
        bus.fpu_pending = '0;
        idle(3);

        // Reset with a buffered response and a pending request
        bus.rsp_ready = 1'b0;
        issue(2'd3, 4'hF, CSR_RW, 1'b0, 5'd9, CSR_MSCRATCH, 32'hDDDD_0004, w);
        drive_req(2'd3, 4'hF, CSR_RW, 1'b0, 5'd9, CSR_MSCRATCH, 32'hFFFF_0006);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        idle(2);
        issue(2'd3, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_MSCRATCH, 32'h0, w);
        issue(2'd1, 4'hF, CSR_RS, 1'b1, 5'd0, CSR_MSCRATCH, 32'h0, w);
        idle(5);

        // Literal expectations that pin the model itself
        chk("rsp_count", 32'(rsp_log0.size()), 32'd17);
        chk("wr_count", 32'(wr_log.size()), 32'd9);
        if (rsp_log0.size() == 17) begin
            for (int k = 0; k < 17; k++) chk("rsp_lane0_literal", rsp_log0[k], exp_rsp0[k]);
            chk("wtid_lane3", rsp_log3[7], 32'd3);
            chk("ltid_lane3", rsp_log3[8], 32'd3);
            chk("gtid_lane3", rsp_log3[9], 32'd27);
        end
        if (wr_log.size() == 9) begin
            chk("wr_rw",     wr_log[0], 32'h1234);
            chk("wr_rs",     wr_log[1], 32'h12F4);
            chk("wr_rc",     wr_log[2], 32'h12F0);
            chk("wr_rw_zero", wr_log[3], 32'h0);
            chk("wr_rs_imm", wr_log[4], 32'h1F);
            chk("wr_bp_c",   wr_log[7], 32'hCCCC_0003);
            chk("wr_pre_rst", wr_log[8], 32'hDDDD_0004);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_csr_unit.md
Name: VX_csr_unit

Overview:
Issue side of the CSR read/write port pair. It takes decoded CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms) from the dispatch stage, reads the CSR data block, computes the read-modify-write value and issues the write. It returns per-thread writeback data to the commit stage through a registered valid/ready output. It also drives the `busy` qualifier used by the cycle counter, and stalls warps with in-flight FPU flag updates.

Parameters:
CORE_ID, 0, core index used for GTID computation
NUM_THREADS, `NUM_THREADS, lanes per warp
NUM_WARPS, `NUM_WARPS, warps per core

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_wid  in  `NW_BITS  warp id
req_tmask  in  NUM_THREADS  active thread mask
req_PC  in  32  instruction PC (passthrough)
req_rd  in  `NR_BITS  destination register
req_wb  in  1  writeback enable
req_op  in  2  csr_op_t: RW/RS/RC
req_use_imm  in  1  source is zero-extended 5-bit immediate
req_imm  in  5  immediate / rs1 index (zero means no-write for RS/RC)
req_addr  in  `CSR_ADDR_BITS  CSR address
req_rs1_data  in  32  lane-0 rs1 value (CSR ops use lane 0)
fpu_pending  in  NUM_WARPS  per-warp outstanding FPU fflags update
read_enable  out  1  to CSR data block
read_addr  out  `CSR_ADDR_BITS
read_wid  out  `NW_BITS
read_data  in  32  combinational read result
write_enable  out  1
write_addr  out  `CSR_ADDR_BITS
write_wid  out  `NW_BITS
write_data  out  `CSR_WIDTH
busy  out  1  any request held or in output buffer
rsp_valid  out  1  commit valid
rsp_ready  in  1  commit ready
rsp_wid, rsp_tmask, rsp_PC, rsp_rd, rsp_wb  out  as request  passthrough
rsp_data  out  NUM_THREADS x 32  per-lane writeback data

Behaviour:
- Reset: rsp_valid=0, busy=0, read_enable=0, write_enable=0; buffer contents are don't-care.
- Output is a one-entry register plus a one-entry skid. req_ready = ~skid_full & ~fpu_stall. rsp_valid is the head register valid.
- fpu_stall = req_valid & fpu_pending[req_wid] & (req_addr is FFLAGS, FRM or FCSR). No read or write is issued while stalled.
- Accept cycle T (fire = req_valid & req_ready):
  - read_enable=fire, read_addr=req_addr, read_wid=req_wid; read_data is sampled in the same cycle.
  - src = req_use_imm ? 32'(req_imm) : req_rs1_data.
  - new value: RW: src; RS: read_data | src; RC: read_data & ~src.
  - write_enable = fire & (op==RW | src_nonzero_field), where src_nonzero_field is req_imm != 0 (rs1 != x0 or immediate != 0). write_addr/write_wid/write_data carry the same cycle's values.
  - The write lands at the end of T, so a request accepted at T+1 reads the updated value. No forwarding is needed.
- Per-lane rsp_data, lane i:
  - WTID/LTID: i.
  - GTID: (CORE_ID*NUM_WARPS + wid)*NUM_THREADS + i.
  - All other CSRs: read_data broadcast.
  - Lanes inactive in tmask carry don't-care data.
- Response latency: rsp_valid asserts at T+1 when the output is empty. Back-to-back accepts sustain one per cycle while rsp_ready=1.
- rsp_ready=0 with head full: the next accept goes to skid, then req_ready drops. When rsp_ready returns, skid moves to head in order.
- Simultaneous pop and push: head takes skid if occupied, else the new entry. Order is strictly FIFO.
- busy = fire | head_valid | skid_valid.
- Reset mid-operation clears both entries. A write issued in the reset cycle is suppressed (write_enable gated by ~reset).

Decomposition:
- Shared package (VX_gpu_types or csr_types): csr_op_t enum {CSR_RW=2'd1, CSR_RS=2'd2, CSR_RC=2'd3} and the csr_rsp_t struct (wid, tmask, PC, rd, wb, data).
- CSR address constants come from the existing define header.
- One natural sub-module: VX_skid_buffer (generic 2-entry valid/ready buffer, parameterised on DATAW) holding csr_rsp_t.

Test Plan:
- RW mstatus=0x1234 from reset → rsp_data lanes = 0x0, write_enable=1 with data 0x1234. Next RS read returns 0x1234.
- RS mstatus src=0x00F0 after the above → rsp 0x1234, write 0x12F4. RC src=0x0004 → rsp 0x12F4, write 0x12F0.
- RS/RC with imm=0 (rs1=x0) → write_enable stays 0 and rsp returns the current value. RW with src 0 → write_enable=1, data 0.
- NUM_THREADS=4, warp 2, CORE_ID=1, NUM_WARPS=4: WTID → 0,1,2,3; GTID → 24,25,26,27.
- rsp_ready low 5 cycles with 3 back-to-back requests → 2 accepted, req_ready=0 on the third. On release, responses emerge in order, with no loss or duplication.
- fpu_pending[1]=1, warp-1 read of FCSR → req_ready=0, read_enable=0 until pending clears. A warp-0 FCSR request is accepted immediately.
